imem_ctrl: RTL and testbench



---
 rtl/imem_pkg.sv | 24 ++
 rtl/imem_ctrl_if.sv | 36 +++
 rtl/imem_ctrl.sv | 144 ++++++++++++++
 tb/tb_imem_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory controller.
// Word depth, fill word, fetch sentinel and FSM state encoding live here.
package imem_pkg;

    localparam int unsigned SIZE          = 128;
    localparam int unsigned AW            = $clog2(SIZE);
    localparam logic [31:0] NOP           = 32'h0000_0013;
    localparam logic [31:0] SENTINEL_ADDR = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    function automatic logic [AW-1:0] word_idx(input logic [31:0] byte_addr);
        return byte_addr[AW+1:2];
    endfunction

    function automatic logic is_oob(input logic [31:0] byte_addr);
        return |byte_addr[31:AW+2];
    endfunction

endpackage

// File: rtl/imem_ctrl_if.sv
// Bundle of fetch, loader and RAM-side signals around imem_ctrl.
// The controller takes the slave view; the surrounding pipeline/loader/RAM take master.
interface imem_ctrl_if
    import imem_pkg::*;
();

    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          cpu_run;
    logic          ld_start;
    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          oob_err;

    modport master (
        output if_req, if_addr, ld_start, ld_valid, ld_data, ld_last, mem_rdata,
        input  if_rvalid, if_rdata, cpu_run, ld_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, oob_err
    );

    modport slave (
        input  if_req, if_addr, ld_start, ld_valid, ld_data, ld_last, mem_rdata,
        output if_rvalid, if_rdata, cpu_run, ld_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, oob_err
    );

endinterface

// File: rtl/imem_ctrl.sv
// Instruction-memory sequencer: clears RAM to NOP, loads a program, then serves fetches.
// Define IMEM_BOUNDS_CHK_EN to reject fetches beyond the array with an oob_err pulse.
module imem_ctrl
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    imem_ctrl_if.slave bus
);

    state_e        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_pend_rd;
    logic          r_pend_hold;
    logic          r_pend_oob;
    logic [31:0]   r_rdata;
    logic          r_rvalid;
    logic          r_oob_err;

    logic          w_cnt_last;
    logic          w_sentinel;
    logic          w_fetch;
    logic          w_oob;
    logic          w_rd;
    logic          w_mem_en;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [31:0]   w_mem_wdata;

    assign w_cnt_last = (r_cnt == {AW{1'b1}});
    assign w_sentinel = (bus.if_addr == SENTINEL_ADDR);
    assign w_fetch    = (r_state == RUN) && bus.if_req;

`ifdef IMEM_BOUNDS_CHK_EN
    assign w_oob = is_oob(bus.if_addr);
`else
    assign w_oob = 1'b0;
`endif

    assign w_rd = w_fetch && !w_sentinel && !w_oob;

    // RAM port steering; held idle while reset is asserted so the first write lands after release
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = {AW{1'b0}};
        w_mem_wdata = 32'h0000_0000;
        if (!rst_n) begin
            w_mem_en = 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    w_mem_en    = 1'b1;
                    w_mem_we    = 1'b1;
                    w_mem_addr  = r_cnt;
                    w_mem_wdata = NOP;
                end
                LOAD: begin
                    w_mem_en    = bus.ld_valid;
                    w_mem_we    = bus.ld_valid;
                    w_mem_addr  = r_cnt;
                    w_mem_wdata = bus.ld_data;
                end
                RUN: begin
                    w_mem_en   = w_rd;
                    w_mem_we   = 1'b0;
                    w_mem_addr = word_idx(bus.if_addr);
                end
                default: begin
                    w_mem_en = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state plus the one-deep fetch response pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_cnt       <= {AW{1'b0}};
            r_pend_rd   <= 1'b0;
            r_pend_hold <= 1'b0;
            r_pend_oob  <= 1'b0;
            r_rdata     <= NOP;
            r_rvalid    <= 1'b0;
            r_oob_err   <= 1'b0;
        end else begin
            // Responses retire regardless of state so a read issued alongside ld_start completes
            r_rvalid  <= r_pend_rd | r_pend_hold | r_pend_oob;
            r_oob_err <= r_pend_oob;
            if (r_pend_rd) begin
                r_rdata <= bus.mem_rdata;
            end else if (r_pend_oob) begin
                r_rdata <= NOP;
            end

            r_pend_rd   <= w_rd;
            r_pend_hold <= w_fetch && w_sentinel;
            r_pend_oob  <= w_fetch && !w_sentinel && w_oob;

            if (bus.ld_start) begin
                r_state <= FILL;
                r_cnt   <= {AW{1'b0}};
            end else begin
                case (r_state)
                    FILL: begin
                        if (w_cnt_last) begin
                            r_state <= LOAD;
                            r_cnt   <= {AW{1'b0}};
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    LOAD: begin
                        if (bus.ld_valid) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (bus.ld_last || w_cnt_last) begin
                                r_state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        r_state <= RUN;
                    end
                    default: begin
                        r_state <= FILL;
                        r_cnt   <= {AW{1'b0}};
                    end
                endcase
            end
        end
    end

    assign bus.cpu_run   = (r_state == RUN);
    assign bus.ld_ready  = (r_state == LOAD);
    assign bus.if_rvalid = r_rvalid;
    assign bus.if_rdata  = r_rdata;
    assign bus.oob_err   = r_oob_err;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl with a behavioural single-port RAM and a fetch scoreboard.
// Expectations for out-of-range fetches follow IMEM_BOUNDS_CHK_EN.
module imem_sp_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:DEPTH-1];

    // Synchronous write or read; read data only changes on a read
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end
endmodule

module tb_imem_ctrl;
    import imem_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [32:0] sb_q[$];
    logic [31:0] model_mem [0:SIZE-1];
    logic [31:0] last_exp;

    imem_ctrl_if bus_if ();

    imem_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    imem_sp_ram #(.DEPTH(SIZE), .AW(AW)) u_ram (
        .clk   (clk),
        .en    (bus_if.mem_en),
        .we    (bus_if.mem_we),
        .addr  (bus_if.mem_addr),
        .wdata (bus_if.mem_wdata),
        .rdata (bus_if.mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_fill();
        for (int k = 0; k < SIZE; k++) model_mem[k] = NOP;
    endtask

    task automatic load_word(input logic [31:0] data, input logic last, input int idx);
        logic [AW-1:0] a;
        a = idx[AW-1:0];
        bus_if.ld_valid = 1'b1;
        bus_if.ld_data  = data;
        bus_if.ld_last  = last;
        #1;
        check($sformatf("load_%0d", idx),
              {27'd0, bus_if.ld_ready, bus_if.mem_en, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata},
              {27'd0, 1'b1, 1'b1, 1'b1, a, data});
        model_mem[idx] = data;
        cyc();
        bus_if.ld_valid = 1'b0;
        bus_if.ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        logic [31:0]   exp;
        logic          oob;
        logic [AW-1:0] idx;
        idx = addr[AW+1:2];
        oob = 1'b0;
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = addr;
        #1;
        if (addr == SENTINEL_ADDR) begin
            check("sentinel_no_ram", {63'd0, bus_if.mem_en}, 64'd0);
            exp = last_exp;
`ifdef IMEM_BOUNDS_CHK_EN
        end else if (|addr[31:AW+2]) begin
            check("oob_no_ram", {63'd0, bus_if.mem_en}, 64'd0);
            exp = NOP;
            oob = 1'b1;
`endif
        end else begin
            check($sformatf("fetch_port_%h", addr),
                  {54'd0, bus_if.mem_en, bus_if.mem_we, bus_if.mem_addr},
                  {54'd0, 1'b1, 1'b0, idx});
            exp = model_mem[idx];
        end
        sb_q.push_back({oob, exp});
        last_exp = exp;
        cyc();
    endtask

    task automatic idle();
        bus_if.if_req = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 8) begin
            cyc();
            k++;
        end
        check("sb_drain", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (bus_if.ld_ready !== 1'b1 && k < 200) begin
            cyc();
            k++;
        end
        check("wait_ld_ready", {63'd0, bus_if.ld_ready}, 64'd1);
    endtask

    // Response monitor: every if_rvalid must match the oldest outstanding fetch
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus_if.if_rvalid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("rvalid_unexpected", 64'd1, 64'd0);
                end else begin
                    logic [32:0] e;
                    e = sb_q.pop_front();
                    check("fetch_rdata", {32'd0, bus_if.if_rdata}, {32'd0, e[31:0]});
                    check("fetch_oob", {63'd0, bus_if.oob_err}, {63'd0, e[32]});
                end
            end else begin
                check("oob_idle", {63'd0, bus_if.oob_err}, 64'd0);
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus_if.if_req   = 1'b0;
        bus_if.if_addr  = 32'h0000_0000;
        bus_if.ld_start = 1'b0;
        bus_if.ld_valid = 1'b0;
        bus_if.ld_data  = 32'h0000_0000;
        bus_if.ld_last  = 1'b0;
        last_exp        = NOP;
        model_fill();

        repeat (3) cyc();
        check("rst_if_rdata", {32'd0, bus_if.if_rdata}, {32'd0, NOP});
        check("rst_flags",
              {58'd0, bus_if.if_rvalid, bus_if.cpu_run, bus_if.ld_ready, bus_if.mem_en, bus_if.mem_we, bus_if.oob_err},
              64'd0);
        check("rst_mem_bus", {25'd0, bus_if.mem_addr, bus_if.mem_wdata}, 64'd0);

        rst_n = 1'b1;
        for (int i = 0; i < SIZE; i++) begin
            logic [AW-1:0] a;
            a = i[AW-1:0];
            // Fetch requests during FILL must be ignored
            bus_if.if_req = (i == 5);
            #1;
            check($sformatf("fill_%0d", i),
                  {21'd0, bus_if.mem_en, bus_if.mem_we, bus_if.cpu_run, bus_if.ld_ready, bus_if.mem_addr, bus_if.mem_wdata},
                  {21'd0, 1'b1, 1'b1, 1'b0, 1'b0, a, NOP});
            cyc();
        end
        idle();
        check("ld_ready_rise", {62'd0, bus_if.ld_ready, bus_if.cpu_run}, {62'd0, 1'b1, 1'b0});

        bus_if.if_req = 1'b1;
        load_word(32'h0050_0093, 1'b0, 0);
        idle();
        load_word(32'h00A0_0113, 1'b0, 1);
        load_word(32'h0020_81B3, 1'b1, 2);
        check("run_after_last", {62'd0, bus_if.cpu_run, bus_if.ld_ready}, {62'd0, 1'b1, 1'b0});

        fetch(32'h0000_0008);
        fetch(SENTINEL_ADDR);
        fetch(32'h0000_000C);
        fetch(32'h0000_0003);
        idle();
        cyc();
        fetch(32'h0000_000A);
        idle();
        drain();

        bus_if.ld_start = 1'b1;
        fetch(32'h0000_0004);
        bus_if.ld_start = 1'b0;
        idle();
        #1;
        check("restart_fill",
              {60'd0, bus_if.cpu_run, bus_if.mem_en, bus_if.mem_we, |bus_if.mem_addr},
              {60'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        model_fill();
        drain();
        wait_ready();

        for (int i = 0; i < SIZE; i++) begin
            load_word(32'hC300_0000 | 32'(i), 1'b0, i);
        end
        check("run_after_full", {62'd0, bus_if.cpu_run, bus_if.ld_ready}, {62'd0, 1'b1, 1'b0});
        fetch(32'h0000_01FC);
        fetch(32'h0000_0000);
        fetch(32'h0000_0200);
        fetch(32'h0000_0404);
        idle();
        drain();

        bus_if.ld_start = 1'b1;
        cyc();
        bus_if.ld_start = 1'b0;
        check("restart_cpu_run", {63'd0, bus_if.cpu_run}, 64'd0);
        model_fill();
        wait_ready();
        load_word(32'h0000_0093, 1'b1, 0);
        fetch(32'h0000_0004);
        fetch(32'h0000_0000);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
